// File: rtl/rv32i_alu_arbiter_pkg.sv
// Shared types and helpers for the two-port ALU arbiter.
package rv32i_alu_arbiter_pkg;

    localparam int NPORTS = 2;
    localparam int OP_W   = 4;
    localparam int FLAG_W = 3;

    typedef struct packed {
        logic equal;
        logic less;
        logic less_signed;
    } rsp_flags_t;

    // last = port granted most recently; the other port wins a tie.
    function automatic logic [1:0] rr_pick(logic [1:0] elig, logic last);
        logic [1:0] g;
        g[0] = elig[0] & (~elig[1] | last);
        g[1] = elig[1] & (~elig[0] | ~last);
        return g;
    endfunction

endpackage

// File: rtl/rv32i_alu_ops.sv
// RV32I ALU operation encodings shared by decode, the ALU and the
// ALU port arbiter.
package rv32i_alu_ops;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

endpackage

// File: rtl/rv32i_alu_rsp_slot.sv
// Per-port response buffer: tracks the in-flight op and holds its
// result until the requester takes it.
module rv32i_alu_rsp_slot
    import rv32i_alu_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              issue_i,
    input  logic              flush_i,
    input  logic              ret_valid_i,
    input  logic [XLEN-1:0]   ret_result_i,
    input  logic [FLAG_W-1:0] ret_flags_i,
    input  logic              rsp_ready_i,
    output logic              inflight_o,
    output logic              rsp_valid_o,
    output logic [XLEN-1:0]   rsp_result_o,
    output logic [FLAG_W-1:0] rsp_flags_o
);

    logic              inflight_q;
    logic              valid_q;
    logic [XLEN-1:0]   result_q;
    logic [FLAG_W-1:0] flags_q;
    logic              discard;
    logic              fill;

    // A flush in the return cycle drops the result.
    assign discard = flush_i;
    assign fill    = inflight_q & ret_valid_i & ~discard;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            // The ALU answers one cycle after issue, so in-flight
            // lasts exactly one cycle whether or not it answered.
            inflight_q <= issue_i;
            if (fill) begin
                valid_q  <= 1'b1;
                result_q <= ret_result_i;
                flags_q  <= ret_flags_i;
            end else if (flush_i || rsp_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign inflight_o   = inflight_q;
    assign rsp_valid_o  = valid_q;
    assign rsp_result_o = result_q;
    assign rsp_flags_o  = flags_q;

endmodule

// File: rtl/rv32i_alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between the execute
// port (0) and the address/branch port (1).
module rv32i_alu_arbiter
    import rv32i_alu_ops::*;
    import rv32i_alu_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [7:0]        req_op_i,
    input  logic [2*XLEN-1:0] req_a_i,
    input  logic [2*XLEN-1:0] req_b_i,
    input  logic [1:0]        flush_i,
    output logic [1:0]        rsp_valid_o,
    input  logic [1:0]        rsp_ready_i,
    output logic [2*XLEN-1:0] rsp_result_o,
    output logic [1:0]        rsp_equal_o,
    output logic [1:0]        rsp_less_o,
    output logic [1:0]        rsp_less_signed_o,
    output logic              alu_valid_o,
    output logic [3:0]        alu_op_o,
    output logic [XLEN-1:0]   alu_a_o,
    output logic [XLEN-1:0]   alu_b_o,
    output logic              alu_clear_o,
    input  logic              alu_valid_i,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic              alu_equal_i,
    input  logic              alu_less_i,
    input  logic              alu_less_signed_i,
    output logic              err_o
);

    logic [1:0] inflight;
    logic [1:0] elig;
    logic [1:0] gnt;
    logic       last_q;
    logic       clear_q;
    logic       err_q;
    rsp_flags_t ret_flags;
    rsp_flags_t slot_flags [NPORTS];

    assign elig = req_valid_i & ~flush_i & ~inflight
                & (~rsp_valid_o | rsp_ready_i) & {2{~clear_q}};
    assign gnt  = rr_pick(elig, last_q);

    assign req_ready_o = gnt;
    assign alu_clear_o = clear_q;
    assign err_o       = err_q;

    assign ret_flags.equal       = alu_equal_i;
    assign ret_flags.less        = alu_less_i;
    assign ret_flags.less_signed = alu_less_signed_i;

    always_comb begin
        alu_valid_o = 1'b0;
        alu_op_o    = '0;
        alu_a_o     = '0;
        alu_b_o     = '0;
        unique case (1'b1)
            gnt[0]: begin
                alu_valid_o = 1'b1;
                alu_op_o    = req_op_i[3:0];
                alu_a_o     = req_a_i[XLEN-1:0];
                alu_b_o     = req_b_i[XLEN-1:0];
            end
            gnt[1]: begin
                alu_valid_o = 1'b1;
                alu_op_o    = req_op_i[7:4];
                alu_a_o     = req_a_i[2*XLEN-1:XLEN];
                alu_b_o     = req_b_i[2*XLEN-1:XLEN];
            end
            default: ;
        endcase
    end

    // last_q resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q  <= 1'b1;
            clear_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            if (|gnt) begin
                last_q <= gnt[1];
            end
            if (alu_valid_i ^ (|inflight)) begin
                err_q <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_slot
        rv32i_alu_rsp_slot #(
            .XLEN(XLEN)
        ) u_slot (
            .clk_i        (clk_i),
            .rst_n_i      (rst_n_i),
            .issue_i      (gnt[p]),
            .flush_i      (flush_i[p]),
            .ret_valid_i  (alu_valid_i),
            .ret_result_i (alu_result_i),
            .ret_flags_i  (ret_flags),
            .rsp_ready_i  (rsp_ready_i[p]),
            .inflight_o   (inflight[p]),
            .rsp_valid_o  (rsp_valid_o[p]),
            .rsp_result_o (rsp_result_o[p*XLEN +: XLEN]),
            .rsp_flags_o  (slot_flags[p])
        );

        assign rsp_equal_o[p]       = slot_flags[p].equal;
        assign rsp_less_o[p]        = slot_flags[p].less;
        assign rsp_less_signed_o[p] = slot_flags[p].less_signed;
    end

endmodule

// File: tb/tb_rv32i_alu_arbiter.sv
// Directed scoreboard bench for the two-port ALU arbiter with a
// behavioural single-cycle ALU answering one cycle after issue.
module tb_rv32i_alu_arbiter;
    import rv32i_alu_ops::*;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [7:0]        req_op;
    logic [2*XLEN-1:0] req_a;
    logic [2*XLEN-1:0] req_b;
    logic [1:0]        flush;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [2*XLEN-1:0] rsp_result;
    logic [1:0]        rsp_equal;
    logic [1:0]        rsp_less;
    logic [1:0]        rsp_less_signed;
    logic              alu_valid_o;
    logic [3:0]        alu_op;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic              alu_clear;
    logic              alu_valid_i;
    logic [XLEN-1:0]   alu_result;
    logic              alu_equal;
    logic              alu_less;
    logic              alu_less_signed;
    logic              err;

    logic ret_v = 1'b0;
    logic inj = 1'b0;

    assign alu_valid_i = ret_v | inj;

    always #5 clk = ~clk;

    rv32i_alu_arbiter #(.XLEN(XLEN)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_op_i          (req_op),
        .req_a_i           (req_a),
        .req_b_i           (req_b),
        .flush_i           (flush),
        .rsp_valid_o       (rsp_valid),
        .rsp_ready_i       (rsp_ready),
        .rsp_result_o      (rsp_result),
        .rsp_equal_o       (rsp_equal),
        .rsp_less_o        (rsp_less),
        .rsp_less_signed_o (rsp_less_signed),
        .alu_valid_o       (alu_valid_o),
        .alu_op_o          (alu_op),
        .alu_a_o           (alu_a),
        .alu_b_o           (alu_b),
        .alu_clear_o       (alu_clear),
        .alu_valid_i       (alu_valid_i),
        .alu_result_i      (alu_result),
        .alu_equal_i       (alu_equal),
        .alu_less_i        (alu_less),
        .alu_less_signed_i (alu_less_signed),
        .err_o             (err)
    );

    typedef struct {
        logic [31:0] r;
        logic        eq;
        logic        lt;
        logic        lts;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;

    function automatic exp_t alu_ref(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        exp_t e;
        e.eq  = (a == b);
        e.lt  = (a < b);
        e.lts = ($signed(a) < $signed(b));
        case (op)
            ALU_ADD:  e.r = a + b;
            ALU_SUB:  e.r = a - b;
            ALU_SLT:  e.r = {31'b0, e.lts};
            ALU_SLTU: e.r = {31'b0, e.lt};
            ALU_AND:  e.r = a & b;
            ALU_OR:   e.r = a | b;
            ALU_XOR:  e.r = a ^ b;
            ALU_SLL:  e.r = a << b[4:0];
            ALU_SRL:  e.r = a >> b[4:0];
            ALU_SRA:  e.r = $unsigned($signed(a) >>> b[4:0]);
            default:  e.r = 32'h0;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Behavioural ALU: answers one cycle after each issue.
    logic cap_v;
    exp_t cap_e;
    initial begin
        forever begin
            @(negedge clk);
            cap_v = alu_valid_o & rst_n;
            cap_e = alu_ref(alu_op, alu_a, alu_b);
            @(posedge clk);
            #1;
            ret_v           = cap_v;
            alu_result      = cap_e.r;
            alu_equal       = cap_e.eq;
            alu_less        = cap_e.lt;
            alu_less_signed = cap_e.lts;
        end
    end

    // Monitor: checks the ALU-side mux, records issues, scores responses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("gnt_onehot", 64'($onehot0(req_ready)), 64'(1));
                if (req_ready[0]) begin
                    chk("issue0_valid", 64'(alu_valid_o), 64'(1));
                    chk("issue0_op", 64'(alu_op), 64'(req_op[3:0]));
                    chk("issue0_a", 64'(alu_a), 64'(req_a[31:0]));
                    chk("issue0_b", 64'(alu_b), 64'(req_b[31:0]));
                    q0.push_back(alu_ref(req_op[3:0], req_a[31:0], req_b[31:0]));
                end else if (req_ready[1]) begin
                    chk("issue1_valid", 64'(alu_valid_o), 64'(1));
                    chk("issue1_op", 64'(alu_op), 64'(req_op[7:4]));
                    chk("issue1_a", 64'(alu_a), 64'(req_a[63:32]));
                    chk("issue1_b", 64'(alu_b), 64'(req_b[63:32]));
                    q1.push_back(alu_ref(req_op[7:4], req_a[63:32], req_b[63:32]));
                end else begin
                    chk("idle_alu", {29'b0, alu_valid_o, alu_op}, 64'(0));
                    chk("idle_ab", {alu_a, alu_b}, 64'(0));
                end
                for (int p = 0; p < 2; p++) begin
                    if (rsp_valid[p] && rsp_ready[p]) begin
                        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
                            chk("stale_rsp", 64'(rsp_valid[p]), 64'(0));
                        end else begin
                            e = (p == 0) ? q0.pop_front() : q1.pop_front();
                            chk("rsp_result", 64'(rsp_result[p*32 +: 32]), 64'(e.r));
                            chk("rsp_equal", 64'(rsp_equal[p]), 64'(e.eq));
                            chk("rsp_less", 64'(rsp_less[p]), 64'(e.lt));
                            chk("rsp_less_signed", 64'(rsp_less_signed[p]), 64'(e.lts));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  exp_g;
        logic [31:0] held;
        int          g0;
        bit          seen;

        req_valid = 2'b00;
        req_op    = 8'h0;
        req_a     = '0;
        req_b     = '0;
        flush     = 2'b00;
        rsp_ready = 2'b11;
        #1;
        rst_n = 1'b0;

        // Reset state, with a request already pending.
        nxt();
        req_valid = 2'b01;
        req_op    = {4'h0, ALU_ADD};
        req_a     = {32'h0, 32'd5};
        req_b     = {32'h0, 32'd7};
        #1;
        chk("rst_clear", 64'(alu_clear), 64'(1));
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_result", rsp_result, 64'(0));
        chk("rst_alu_valid", 64'(alu_valid_o), 64'(0));

        // Release: one clear cycle, then port 0 ADD 5,7.
        mid();
        rst_n = 1'b1;
        #1;
        chk("clear_cycle", 64'(alu_clear), 64'(1));
        chk("clear_no_gnt", 64'(req_ready), 64'(0));
        nxt();
        mid();
        chk("clear_done", 64'(alu_clear), 64'(0));
        chk("add_gnt", 64'(req_ready), 64'(1));
        nxt();
        req_valid = 2'b00;
        mid();
        chk("add_lat1", 64'(rsp_valid), 64'(0));
        nxt();
        mid();
        chk("add_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("add_result", 64'(rsp_result[31:0]), 64'(12));
        chk("add_equal", 64'(rsp_equal[0]), 64'(0));
        chk("add_less", 64'(rsp_less[0]), 64'(1));

        // Both ports every cycle: strict alternation, ALU busy each cycle.
        nxt();
        req_valid = 2'b11;
        req_op    = {ALU_XOR, ALU_SUB};
        exp_g     = 2'b10;
        for (int i = 0; i < 8; i++) begin
            req_a = {32'h1234_0000 + 32'(i), 32'd3};
            req_b = {32'h00FF_00FF, 32'd5};
            mid();
            chk("alt_gnt", 64'(req_ready), 64'(exp_g));
            chk("alt_alu_busy", 64'(alu_valid_o), 64'(1));
            if (rsp_valid[0]) chk("sub_result", 64'(rsp_result[31:0]), 64'(32'hFFFF_FFFE));
            exp_g = {exp_g[0], exp_g[1]};
            nxt();
        end
        req_valid = 2'b00;
        repeat (3) begin
            mid();
            nxt();
        end
        chk("alt_drain0", 64'(q0.size()), 64'(0));
        chk("alt_drain1", 64'(q1.size()), 64'(0));

        // Port 1 backpressured: payload holds, port 0 keeps issuing.
        req_valid = 2'b11;
        req_op    = {ALU_OR, ALU_ADD};
        req_a     = {32'h0000_00A0, 32'd100};
        req_b     = {32'h0000_000B, 32'd1};
        rsp_ready = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            mid();
            if (rsp_valid[1]) seen = 1'b1;
            else nxt();
        end
        chk("bp_rsp_seen", 64'(seen), 64'(1));
        held = rsp_result[63:32];
        chk("bp_payload", 64'(held), 64'(32'hAB));
        g0 = 0;
        for (int k = 0; k < 6; k++) begin
            nxt();
            req_a[31:0] = 32'd200 + 32'(k);
            mid();
            chk("bp_hold_valid", 64'(rsp_valid[1]), 64'(1));
            chk("bp_hold_payload", 64'(rsp_result[63:32]), 64'(held));
            chk("bp_no_regrant", 64'(req_ready[1]), 64'(0));
            g0 += int'(req_ready[0]);
        end
        chk("bp_port0_rate", 64'(g0), 64'(3));
        nxt();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (3) begin
            mid();
            nxt();
        end
        chk("bp_drain0", 64'(q0.size()), 64'(0));
        chk("bp_drain1", 64'(q1.size()), 64'(0));

        // Flush port 0 the cycle after issuing SLL; port 1 unaffected.
        req_valid = 2'b01;
        req_op    = {ALU_AND, ALU_SLL};
        req_a     = {32'h0000_F0F0, 32'd1};
        req_b     = {32'h0000_FF00, 32'd4};
        mid();
        chk("fl_gnt0", 64'(req_ready), 64'(1));
        nxt();
        req_valid = 2'b10;
        flush     = 2'b01;
        q0.delete();
        mid();
        chk("fl_gnt1", 64'(req_ready), 64'(2));
        nxt();
        req_valid = 2'b00;
        flush     = 2'b00;
        mid();
        chk("fl_no_rsp0_a", 64'(rsp_valid[0]), 64'(0));
        nxt();
        mid();
        chk("fl_rsp", 64'(rsp_valid), 64'(2));
        chk("fl_rsp1_result", 64'(rsp_result[63:32]), 64'(32'hF000));
        nxt();
        mid();
        chk("fl_no_rsp0_b", 64'(rsp_valid[0]), 64'(0));

        // Spurious ALU return: sticky error.
        chk("err_before", 64'(err), 64'(0));
        nxt();
        inj = 1'b1;
        mid();
        nxt();
        inj = 1'b0;
        repeat (3) begin
            mid();
            chk("err_sticky", 64'(err), 64'(1));
            nxt();
        end

        // Reset while an op is in flight.
        req_valid = 2'b11;
        req_op    = {ALU_SLT, ALU_ADD};
        req_a     = {32'hFFFF_FFFD, 32'h10};
        req_b     = {32'd2, 32'h20};
        mid();
        chk("mr_gnt", 64'(|req_ready), 64'(1));
        nxt();
        #2;
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        chk("mr_clear", 64'(alu_clear), 64'(1));
        chk("mr_alu_valid", 64'(alu_valid_o), 64'(0));
        chk("mr_ready", 64'(req_ready), 64'(0));
        chk("mr_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mr_err", 64'(err), 64'(0));
        chk("mr_result", rsp_result, 64'(0));
        mid();
        nxt();
        rst_n = 1'b1;
        #1;
        chk("mr_clear_cycle", 64'(req_ready), 64'(0));
        mid();
        chk("mr_no_stale_a", 64'(rsp_valid), 64'(0));
        nxt();
        mid();
        chk("mr_tie_port0", 64'(req_ready), 64'(1));
        chk("mr_no_stale_b", 64'(rsp_valid), 64'(0));
        nxt();
        mid();
        chk("mr_then_port1", 64'(req_ready), 64'(2));
        nxt();
        req_valid = 2'b00;
        repeat (3) begin
            mid();
            nxt();
        end
        chk("mr_drain0", 64'(q0.size()), 64'(0));
        chk("mr_drain1", 64'(q1.size()), 64'(0));
        chk("mr_err_end", 64'(err), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32i_alu_arbiter.md
RV32I_ALU_ARBITER -- requirements
Module: rv32i_alu_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; port count fixed at 2 (port 0 = execute, port 1 = address/branch unit).
REQ-002 SHALL have clk_i  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid_i  input  2  per-port request valid.
REQ-005 SHALL have req_ready_o  output  2  per-port grant; request accepted when valid & ready.
REQ-006 SHALL have req_op_i  input  8  port p operation in bits [4p+3:4p].
REQ-007 SHALL have req_a_i, req_b_i  input  2*XLEN each  port p operand in slice [p*XLEN +: XLEN].
REQ-008 SHALL have flush_i  input  2  per-port discard of outstanding work.
REQ-009 SHALL have rsp_valid_o  output  2, and rsp_ready_i  input  2  per-port response handshake.
REQ-010 SHALL have rsp_result_o  output  2*XLEN, and rsp_equal_o, rsp_less_o, rsp_less_signed_o  output  2 each  per-port response payload.
REQ-011 SHALL have alu_valid_o  output  1, alu_op_o  output  4, alu_a_o, alu_b_o  output  XLEN, alu_clear_o  output  1  drive to the ALU.
REQ-012 SHALL have alu_valid_i  input  1, alu_result_i  input  XLEN, alu_equal_i, alu_less_i, alu_less_signed_i  input  1  ALU return.
REQ-013 SHALL have err_o  output  1  sticky protocol error.

Function
REQ-014 Port p eligible iff req_valid_i[p] & ~flush_i[p] & ~inflight[p] & (~rsp_valid_o[p] | rsp_ready_i[p]) & ~alu_clear_o.
REQ-015 At most one grant per cycle; req_ready_o combinational from eligibility and round-robin pointer.
REQ-016 One port eligible -> it is granted; both eligible -> grant the port not granted last; pointer updates only on a grant.
REQ-017 On grant: alu_valid_o=1 and alu_op_o/alu_a_o/alu_b_o = granted port's fields, same cycle (combinational mux); otherwise alu_valid_o=0, alu_op_o/a/b=0.
REQ-018 On grant, inflight[p] set at next edge; ALU return expected exactly one cycle after issue (alu_valid_i).
REQ-019 On alu_valid_i with inflight[p]: clear inflight[p]; if not flushed, latch result and flags into port p response slot, rsp_valid_o[p]=1 next cycle.
REQ-020 Latency: issue cycle t -> rsp_valid_o at t+2; per-port throughput one op per 2 cycles; alternating ports yields one ALU op per cycle.
REQ-021 rsp_valid_o[p] holds with stable payload until rsp_ready_i[p]; clears at edge where valid & ready, unless refilled same edge.
REQ-022 flush_i[p]: clears rsp_valid_o[p] next edge, marks in-flight op discarded (its return dropped, inflight still cleared), blocks grant that cycle; other port unaffected; alu_clear_o not asserted by flush.
REQ-023 alu_valid_i with no inflight bit set, or inflight set and alu_valid_i low one cycle after issue: err_o=1, stays set until reset; inflight cleared regardless.
REQ-024 Simultaneous rsp handshake and new return on same port cannot occur (REQ-014 prevents); flush and return same cycle: flush wins.

Reset
REQ-025 While rst_n_i low: inflight=0, rsp_valid_o=0, rsp payloads=0, pointer=1 (port 0 wins first tie), err_o=0, alu_clear_o=1.
REQ-026 alu_clear_o SHALL deassert at first rising edge after rst_n_i release, giving the ALU one full synchronous clear cycle; no grants while high.
REQ-027 Reset mid-operation abandons all in-flight work; no response emitted for it.

Structure
REQ-028 ALU operation codes (ADD 0000, SUB 1000, SLT 0010, SLTU 0011, AND 0111, OR 0110, XOR 0100, SLL 0001, SRL 0101, SRA 1101) SHALL live in a shared include, rv32i_alu_ops, used by decode, ALU and this block.
REQ-029 Per-port response buffer SHALL be sub-module rv32i_alu_rsp_slot (inflight, discard, valid, payload), instantiated twice.

Verification
REQ-030 Reset release -> alu_clear_o high one cycle, then port 0 ADD 5,7 -> alu_valid_o same cycle, rsp_valid_o[0]=1 two cycles later, result 12, equal 0, less 1.
REQ-031 Both ports valid every cycle, rsp_ready=11 -> grants alternate 0,1,0,1; alu_valid_o high every cycle; results match SUB 3-5=0xFFFFFFFE and XOR operations.
REQ-032 Port 1 rsp_ready_i low 5 cycles -> rsp payload stable, port 1 never re-granted, port 0 continues at one op per 2 cycles.
REQ-033 flush_i[0] the cycle after issuing port 0 SLL 1<<4 -> no rsp_valid_o[0], port 1 response from same period delivered intact.
REQ-034 alu_valid_i pulsed with nothing in flight -> err_o=1 and stays set; rst_n_i asserted mid-issue -> all outputs to reset values immediately, no stale response after release.
